// File: rtl/psum_drain_pkg.sv
// Shared definitions for the partial-sum drain block.
//   state_t     : drain FSM states
//   DEF_OWIDTH  : default requantized element width
//   DEF_PACK    : default elements per output word
package psum_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_OWIDTH = 8;
  localparam int DEF_PACK   = 4;

endpackage

// File: rtl/psum_requant.sv
// Requantization stage: ReLU, round-half-up bias, arithmetic right shift and
// signed saturation, registered as a single pipeline stage.
// Ports:
//   clk, rst           clock, async active-high reset
//   in_valid, in_last  element present / element closes the pass
//   din                signed accumulated sum
//   shift, relu_en     requantization controls (already latched by caller)
//   q_valid, q_last    registered copies of in_valid / in_last
//   q                  registered saturated element
module psum_requant #(
  parameter int DWIDTH = 32,
  parameter int OWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic signed [DWIDTH-1:0] din,
  input  logic [4:0]               shift,
  input  logic                     relu_en,
  output logic                     q_valid,
  output logic                     q_last,
  output logic [OWIDTH-1:0]        q
);

  // Saturation bounds expressed at the DWIDTH+1 working width.
  localparam logic signed [DWIDTH:0] QMAX =
    $signed({{(DWIDTH-OWIDTH+2){1'b0}}, {(OWIDTH-1){1'b1}}});
  localparam logic signed [DWIDTH:0] QMIN =
    $signed({{(DWIDTH-OWIDTH+2){1'b1}}, {(OWIDTH-1){1'b0}}});

  logic signed [DWIDTH:0] ext, bias, sum, shd, sat;

  always_comb begin
    bias = '0;
    if (shift != 5'd0) bias = $signed({{DWIDTH{1'b0}}, 1'b1} << (shift - 5'd1));
    // ReLU zeroes the value before rounding; 0 + bias always shifts back to 0.
    ext = (relu_en && din[DWIDTH-1]) ? '0 : {din[DWIDTH-1], din};
    // One extra bit keeps the bias add from wrapping near +max.
    sum = ext + bias;
    shd = sum >>> shift;
    if (shd > QMAX)      sat = QMAX;
    else if (shd < QMIN) sat = QMIN;
    else                 sat = shd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_last  <= 1'b0;
      q       <= '0;
    end else begin
      q_valid <= in_valid;
      q_last  <= in_valid & in_last;
      if (in_valid) q <= sat[OWIDTH-1:0];
    end
  end

endmodule

// File: rtl/psum_drain.sv
// Partial-sum drain: accepts a burst of accumulated results, requantizes each,
// packs PACK elements little-endian into a word and queues words with their
// output-buffer address in a first-word-fall-through FIFO.
// Ports:
//   clk, rst                      clock, async active-high reset
//   start, base_addr, out_len,    pass configuration, latched on start in IDLE
//   shift, relu_en
//   result_valid, result          incoming results, no backpressure
//   out_valid/out_ready           output word handshake
//   out_addr, out_data, out_strb  word address, packed data, lane mask
//   busy, done                    FSM status, done is a one-cycle pulse
//   err_ovf, err_unexp            sticky errors, cleared by start or rst
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int OWIDTH = DEF_OWIDTH,
  parameter int PACK   = DEF_PACK,
  parameter int AWIDTH = 10,
  parameter int FDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [AWIDTH-1:0]        base_addr,
  input  logic [15:0]              out_len,
  input  logic [4:0]               shift,
  input  logic                     relu_en,
  input  logic                     result_valid,
  input  logic signed [DWIDTH-1:0] result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AWIDTH-1:0]        out_addr,
  output logic [OWIDTH*PACK-1:0]   out_data,
  output logic [PACK-1:0]          out_strb,
  output logic                     busy,
  output logic                     done,
  output logic                     err_ovf,
  output logic                     err_unexp
);

  localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PW = $clog2(FDEPTH);
  localparam int WW = OWIDTH * PACK;

  state_t      state;
  logic [15:0] cnt, len_q;
  logic [4:0]  shift_q;
  logic        relu_q;

  logic start_go, accept, last, drained;

  assign start_go = (state == IDLE) && start;
  assign accept   = (state == RUN) && result_valid;
  assign last     = accept && ((cnt + 16'd1) == len_q);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      err_unexp <= 1'b0;
    end else begin
      if (result_valid && state != RUN) err_unexp <= 1'b1;
      case (state)
        IDLE: if (start) begin
          len_q     <= out_len;
          shift_q   <= shift;
          relu_q    <= relu_en;
          cnt       <= '0;
          err_unexp <= 1'b0;
          state     <= (out_len == 16'd0) ? DONE : RUN;
        end
        RUN: if (result_valid) begin
          cnt <= cnt + 16'd1;
          if (last) state <= FLUSH;
        end
        FLUSH: if (drained) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // ---------------- requant stage ----------------
  logic              rq_valid, rq_last;
  logic [OWIDTH-1:0] rq_q;

  psum_requant #(.DWIDTH(DWIDTH), .OWIDTH(OWIDTH)) u_requant (
    .clk     (clk),
    .rst     (rst),
    .in_valid(accept),
    .in_last (last),
    .din     (result),
    .shift   (shift_q),
    .relu_en (relu_q),
    .q_valid (rq_valid),
    .q_last  (rq_last),
    .q       (rq_q)
  );

  // ---------------- pack stage ----------------
  logic [LW-1:0]     lane;
  logic [WW-1:0]     pack_data, merged_data, word_data;
  logic [PACK-1:0]   pack_strb, merged_strb, word_strb;
  logic [AWIDTH-1:0] next_addr, word_addr;
  logic              word_vld;

  always_comb begin
    merged_data = pack_data;
    merged_strb = pack_strb;
    for (int k = 0; k < PACK; k++) begin
      if (lane == LW'(k)) begin
        merged_data[k*OWIDTH +: OWIDTH] = rq_q;
        merged_strb[k]                  = 1'b1;
      end
    end
  end

  // A word closes on the last lane or on the pass's last element; it sits in
  // word_* for exactly one cycle while the FIFO push is attempted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane      <= '0;
      pack_data <= '0;
      pack_strb <= '0;
      word_vld  <= 1'b0;
      word_data <= '0;
      word_strb <= '0;
      word_addr <= '0;
      next_addr <= '0;
    end else begin
      word_vld <= 1'b0;
      if (start_go) begin
        lane      <= '0;
        pack_data <= '0;
        pack_strb <= '0;
        next_addr <= base_addr;
      end else if (rq_valid) begin
        if (rq_last || lane == LW'(PACK-1)) begin
          word_vld  <= 1'b1;
          word_data <= merged_data;
          word_strb <= merged_strb;
          word_addr <= next_addr;
          next_addr <= next_addr + AWIDTH'(1);
          lane      <= '0;
          pack_data <= '0;
          pack_strb <= '0;
        end else begin
          lane      <= lane + LW'(1);
          pack_data <= merged_data;
          pack_strb <= merged_strb;
        end
      end
    end
  end

  // ---------------- output FIFO ----------------
  logic [WW-1:0]     mem_data [FDEPTH];
  logic [AWIDTH-1:0] mem_addr [FDEPTH];
  logic [PACK-1:0]   mem_strb [FDEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              full, push, pop;

  assign full = (count == (PW+1)'(FDEPTH));
  assign pop  = (count != '0) && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = word_vld && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= word_data;
      mem_addr[wr_ptr] <= word_addr;
      mem_strb[wr_ptr] <= word_strb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (start_go)               err_ovf <= 1'b0;
      else if (word_vld && !push) err_ovf <= 1'b1;
    end
  end

  assign drained = !rq_valid && (lane == '0) && !word_vld && (count == '0);

  // Storage is not reset, so the head entry is masked until it is valid.
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_addr  = out_valid ? mem_addr[rd_ptr] : '0;
  assign out_strb  = out_valid ? mem_strb[rd_ptr] : '0;

endmodule

// File: tb/tb_psum_drain.sv
module tb_psum_drain;

  localparam int DW = 32, OW = 8, PK = 4, AW = 10, FD = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [AW-1:0]        base_addr = '0;
  logic [15:0]          out_len = '0;
  logic [4:0]           shift = '0;
  logic                 relu_en = 1'b0;
  logic                 result_valid = 1'b0;
  logic signed [DW-1:0] result = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [AW-1:0]        out_addr;
  logic [OW*PK-1:0]     out_data;
  logic [PK-1:0]        out_strb;
  logic                 busy, done, err_ovf, err_unexp;

  psum_drain #(.DWIDTH(DW), .OWIDTH(OW), .PACK(PK), .AWIDTH(AW), .FDEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .out_len(out_len),
    .shift(shift), .relu_en(relu_en), .result_valid(result_valid), .result(result),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_strb(out_strb), .busy(busy), .done(done),
    .err_ovf(err_ovf), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    strb;
  } exp_t;

  exp_t expq[$];
  int   res[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Requantization straight from the arithmetic rules, in 64-bit integers.
  function automatic int rq_model(input int r, input int sh, input bit relu);
    longint v;
    v = r;
    if (relu && v < 0) return 0;
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  // Expected word stream for a pass over res[0..len-1]; keep limits how many
  // words the FIFO is expected to retain.
  task automatic build_expect(input logic [AW-1:0] base, input int len, input int sh,
                              input bit relu, input int keep);
    int nw;
    nw = (len + PK - 1) / PK;
    for (int w = 0; w < nw && w < keep; w++) begin
      exp_t e;
      e.addr = base + AW'(w);
      e.data = '0;
      e.strb = '0;
      for (int k = 0; k < PK; k++) begin
        if (w*PK + k < len) begin
          e.data[8*k +: 8] = 8'(rq_model(res[w*PK + k], sh, relu));
          e.strb[k] = 1'b1;
        end
      end
      expq.push_back(e);
    end
  endtask

  task automatic start_pass(input logic [AW-1:0] base, input int len, input int sh, input bit relu);
    @(posedge clk); #1;
    base_addr = base; out_len = 16'(len); shift = 5'(sh); relu_en = relu; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive(input int len);
    for (int i = 0; i < len; i++) begin
      result_valid = 1'b1;
      result = res[i];
      @(posedge clk); #1;
    end
    result_valid = 1'b0;
    result = '0;
  endtask

  task automatic finish_pass(input int stall);
    bit got;
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
    check("words_left", expq.size(), 0);
    expq.delete();
  endtask

  // Compare process: every transfer against the model queue, plus hold checks
  // on every stalled cycle.
  initial begin
    bit            stall_prev;
    logic [31:0]   pd;
    logic [AW-1:0] pa;
    logic [3:0]    ps;
    exp_t          e;
    stall_prev = 1'b0;
    pd = '0; pa = '0; ps = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", out_data, pd);
          check("hold_addr", 32'(out_addr), 32'(pa));
          check("hold_strb", 32'(out_strb), 32'(ps));
        end
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word: got addr 0x%0h data 0x%0h, required no word",
                     out_addr, out_data);
          end else begin
            e = expq.pop_front();
            check("word_data", out_data, e.data);
            check("word_addr", 32'(out_addr), 32'(e.addr));
            check("word_strb", 32'(out_strb), 32'(e.strb));
          end
        end
        stall_prev = out_valid && !out_ready;
        pd = out_data; pa = out_addr; ps = out_strb;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", out_data, 0);
    check("rst_addr", 32'(out_addr), 0);
    check("rst_strb", 32'(out_strb), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_errs", {30'd0, err_ovf, err_unexp}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // ---- results 1..8, shift 0 ----
    for (int i = 0; i < 8; i++) res[i] = i + 1;
    build_expect(10'h010, 8, 0, 1'b0, 99);
    check("model_w0", expq[0].data, 32'h04030201);
    check("model_w1", expq[1].data, 32'h08070605);
    start_pass(10'h010, 8, 0, 1'b0);
    check("busy_run", 32'(busy), 1);
    drive(8);
    finish_pass(0);
    @(negedge clk);
    check("busy_idle", 32'(busy), 0);
    check("errs_clean", {30'd0, err_ovf, err_unexp}, 0);

    // ---- latency: single element, valid 3 cycles after sampling ----
    res[0] = 7;
    build_expect(10'h020, 1, 0, 1'b0, 99);
    start_pass(10'h020, 1, 0, 1'b0);
    result_valid = 1'b1; result = 7;
    @(posedge clk); #1;
    result_valid = 1'b0; result = '0;
    @(negedge clk);
    @(negedge clk);
    check("lat_early", 32'(out_valid), 0);
    @(negedge clk);
    check("lat_exact", 32'(out_valid), 1);
    finish_pass(0);

    // ---- rounding / saturation, shift 4 ----
    res[0] = 24; res[1] = 23; res[2] = -24; res[3] = 5000; res[4] = -5000;
    check("model_round", rq_model(24, 4, 1'b0), 2);
    check("model_negsat", rq_model(-5000, 4, 1'b0), 32'hFFFFFF80);
    build_expect(10'h030, 5, 4, 1'b0, 99);
    check("model_q_w0", expq[0].data, 32'h7FFF0102);
    check("model_q_w1", expq[1].data, 32'h00000080);
    start_pass(10'h030, 5, 4, 1'b0);
    drive(5);
    finish_pass(0);

    // ---- same with ReLU ----
    build_expect(10'h040, 5, 4, 1'b1, 99);
    check("model_relu_w0", expq[0].data, 32'h7F000102);
    check("model_relu_s1", 32'(expq[1].strb), 32'h1);
    start_pass(10'h040, 5, 4, 1'b1);
    drive(5);
    finish_pass(0);

    // ---- partial last word ----
    for (int i = 0; i < 6; i++) res[i] = i + 1;
    build_expect(10'h050, 6, 0, 1'b0, 99);
    check("model_part_d", expq[1].data, 32'h00000605);
    check("model_part_s", 32'(expq[1].strb), 32'h3);
    start_pass(10'h050, 6, 0, 1'b0);
    drive(6);
    finish_pass(0);

    // ---- overflow: 6 words into a 4-deep FIFO while stalled ----
    for (int i = 0; i < 24; i++) res[i] = i + 1;
    build_expect(10'h100, 24, 0, 1'b0, FD);
    check("model_ovf_n", expq.size(), 4);
    out_ready = 1'b0;
    start_pass(10'h100, 24, 0, 1'b0);
    drive(24);
    finish_pass(10);
    check("err_ovf", 32'(err_ovf), 1);

    // ---- address wrap ----
    for (int i = 0; i < 12; i++) res[i] = 100 + i;
    build_expect(10'h3FF, 12, 0, 1'b0, 99);
    check("model_wrap_a1", 32'(expq[1].addr), 32'h000);
    check("model_wrap_a2", 32'(expq[2].addr), 32'h001);
    start_pass(10'h3FF, 12, 0, 1'b0);
    check("ovf_cleared", 32'(err_ovf), 0);
    drive(12);
    finish_pass(0);

    // ---- reset mid-RUN ----
    for (int i = 0; i < 8; i++) res[i] = i + 1;
    out_ready = 1'b0;
    start_pass(10'h060, 8, 0, 1'b0);
    drive(6);
    @(posedge clk); #1;
    check("pre_rst_word", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_addr", 32'(out_addr), 0);
    check("mid_rst_busy", 32'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 0);
    build_expect(10'h070, 8, 0, 1'b0, 99);
    start_pass(10'h070, 8, 0, 1'b0);
    drive(8);
    finish_pass(0);

    // ---- result_valid in IDLE ----
    @(posedge clk); #1;
    result_valid = 1'b1; result = 99;
    repeat (2) @(posedge clk);
    #1 result_valid = 1'b0; result = '0;
    @(negedge clk);
    check("err_unexp", 32'(err_unexp), 1);
    repeat (6) @(negedge clk);
    check("unexp_no_word", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++) res[i] = -(i + 1);
    build_expect(10'h080, 4, 0, 1'b0, 99);
    start_pass(10'h080, 4, 0, 1'b0);
    check("unexp_cleared", 32'(err_unexp), 0);
    drive(4);
    finish_pass(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/psum_drain.md
PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, width of the accumulated result from the partial-sum buffer.
REQ-002 SHALL have parameter OWIDTH, default 8, width of one requantized output element.
REQ-003 SHALL have parameter PACK, default 4, number of elements packed per output word.
REQ-004 SHALL have parameter AWIDTH, default 10, output-buffer word address width.
REQ-005 SHALL have parameter FDEPTH, default 4, output FIFO depth in words, power of two.
REQ-006 SHALL use one clock; reset is asynchronous and active-high: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have the following ports:
- start  in  1  one-cycle pulse; latches configuration.
- base_addr  in  AWIDTH  first word address.
- out_len  in  16  results expected in this pass.
- shift  in  5  requantization right-shift amount.
- relu_en  in  1  clamp negative values to zero.
- result_valid  in  1  result present this cycle; no backpressure possible.
- result  in  DWIDTH (signed)  accumulated sum.
- out_valid  out  1  output word available.
- out_ready  in  1  downstream accepts the word.
- out_addr  out  AWIDTH  word address.
- out_data  out  OWIDTH*PACK  packed elements.
- out_strb  out  PACK  per-element valid mask.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.
- err_ovf  out  1  sticky: word dropped because the FIFO was full.
- err_unexp  out  1  sticky: result_valid received outside RUN.

Function
REQ-008 The FSM SHALL have the states IDLE, RUN, FLUSH and DONE.
REQ-009 In IDLE, start SHALL latch the configuration, clear the result counter and lane index, and go to RUN; if out_len==0 it SHALL go directly to DONE.
REQ-010 In RUN, every cycle with result_valid SHALL be accepted unconditionally and the counter incremented.
REQ-011 When the counter reaches out_len, RUN SHALL go to FLUSH.
REQ-012 FLUSH SHALL wait until the pipeline and pack register are drained and the FIFO is empty, then go to DONE.
REQ-013 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-014 start outside IDLE SHALL be ignored.
REQ-015 Requantization SHALL be applied in this order:
- if relu_en and result<0, the value is 0;
- otherwise add the rounding bias 2^(shift-1) (no bias when shift==0) in DWIDTH+1 bits;
- arithmetic right shift by shift;
- saturate to signed OWIDTH, [-128,127] at the default width.
REQ-016 Requantization SHALL be registered as one pipeline stage.
REQ-017 Packing SHALL be little-endian: element k of a word occupies bits [OWIDTH*k +: OWIDTH]. The lane index wraps at PACK.
REQ-018 A full word SHALL be pushed to the FIFO with out_strb all ones.
REQ-019 If the last result of a pass leaves a partial word, that word SHALL be pushed with unused lanes zero and out_strb set only for the filled lanes.
REQ-020 out_addr SHALL start at base_addr and increment by 1 per pushed word, wrapping modulo 2^AWIDTH.
REQ-021 With an empty FIFO, out_valid SHALL rise exactly 3 cycles after the cycle in which the word's last result was sampled.
REQ-022 The FIFO SHALL be first-word-fall-through. A word transfers when out_valid&out_ready; out_valid, out_data, out_addr and out_strb SHALL be held stable while out_valid&~out_ready.
REQ-023 A push and a pop in the same cycle on a full FIFO SHALL succeed without error.
REQ-024 A push to a full FIFO without a simultaneous pop SHALL drop that word and set err_ovf.
REQ-025 result_valid in IDLE, FLUSH or DONE SHALL be discarded and set err_unexp.
REQ-026 err_ovf and err_unexp SHALL clear only on start or rst.
REQ-027 busy SHALL equal (state!=IDLE).

Reset
REQ-028 rst SHALL asynchronously force state IDLE and clear the counter, lane index, pipeline valid, pack register and FIFO pointers.
REQ-029 During and after rst, all outputs SHALL be 0, with out_addr=0.
REQ-030 A reset asserted mid-pass SHALL discard all buffered words; no partial word is emitted.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, RUN, FLUSH, DONE) and the default OWIDTH and PACK constants.
REQ-032 The round/shift/ReLU/saturate datapath SHALL be a sub-module psum_requant with a registered output. The FIFO and FSM SHALL be inline.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- out_len=8, shift=0, relu_en=0, results 1..8 back-to-back, out_ready=1 -> two words 0x04030201 and 0x08070605, strb 0xF, addresses base and base+1, then done.
- shift=4, results 24, 23, -24, 5000, -5000 with relu_en=0 -> 2, 1, -1, 127, -128. With relu_en=1, the negative inputs give 0.
- out_len=6 -> second word has lanes 2..3 zero, out_strb=0x3.
- out_ready=0 while 6 words arrive, FDEPTH=4 -> err_ovf=1, exactly 4 words are later delivered in order, and data stays stable while stalled.
- base_addr=0x3FF, 3 words -> addresses 0x3FF, 0x000, 0x001.
- rst mid-RUN -> outputs zero immediately; a new start completes a clean pass. result_valid in IDLE -> err_unexp=1 and no word is emitted.
